// File: rtl/alu_exec_stage.sv
// Registered execute-stage ALU with valid/ready handshake on both sides.
// Define ALU_SERIAL_SHIFT_EN to replace the barrel shifter with a 1-bit/cycle serial shifter.
module alu_exec_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero,
  output logic              busy
);

  localparam int unsigned ShW = $clog2(DATA_W);

  typedef enum logic [1:0] {StEmpty, StShift, StFull} state_e;

  state_e            r_state;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              w_accept;
  logic [ShW-1:0]    w_shamt;
  logic [DATA_W-1:0] w_result;

  assign w_shamt   = SrcB[ShW-1:0];
  assign in_ready  = (r_state == StEmpty) || ((r_state == StFull) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == StFull);
  assign ALUResult = r_result;
  assign Zero      = r_zero;

`ifdef ALU_SERIAL_SHIFT_EN
  logic [DATA_W-1:0] r_shift_val;
  logic [ShW-1:0]    r_shift_cnt;
  logic              r_shift_left;
  logic              r_shift_arith;
  logic [DATA_W-1:0] w_shift_next;
  logic              w_is_shift;

  assign w_is_shift = (Operation == 4'b0101) || (Operation == 4'b0111) ||
                      (Operation == 4'b1101);
  assign busy       = (r_state == StShift);

  always_comb begin
    w_shift_next = r_shift_val;
    if (r_shift_left) begin
      w_shift_next = {r_shift_val[DATA_W-2:0], 1'b0};
    end else begin
      // MSB of the working value is still A's sign bit, so it doubles as the SRA fill.
      w_shift_next = {r_shift_arith & r_shift_val[DATA_W-1], r_shift_val[DATA_W-1:1]};
    end
  end
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    w_result = '0;
    case (Operation)
      4'b0000: w_result = SrcA & SrcB;
      4'b0001: w_result = SrcA ^ SrcB;
      4'b0011: w_result = SrcA | SrcB;
      4'b0010: w_result = SrcA - SrcB;
      4'b0100: w_result = SrcA + SrcB;
`ifdef ALU_SERIAL_SHIFT_EN
      // Only reaches the result register for a zero shift amount.
      4'b0101, 4'b0111, 4'b1101: w_result = SrcA;
`else
      4'b0101: w_result = SrcA >> w_shamt;
      4'b0111: w_result = $signed(SrcA) >>> w_shamt;
      4'b1101: w_result = SrcA << w_shamt;
`endif
      4'b1000: w_result = {{(DATA_W-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      4'b1010: w_result = SrcB;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= StEmpty;
      r_result      <= '0;
      r_zero        <= 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
      r_shift_val   <= '0;
      r_shift_cnt   <= '0;
      r_shift_left  <= 1'b0;
      r_shift_arith <= 1'b0;
`endif
    end else begin
      case (r_state)
        StEmpty, StFull: begin
          if (w_accept) begin
`ifdef ALU_SERIAL_SHIFT_EN
            if (w_is_shift && (w_shamt != '0)) begin
              r_state       <= StShift;
              r_shift_val   <= SrcA;
              r_shift_cnt   <= w_shamt;
              r_shift_left  <= Operation[3];
              r_shift_arith <= Operation[1];
            end else begin
              r_state  <= StFull;
              r_result <= w_result;
              r_zero   <= (w_result == '0);
            end
`else
            r_state  <= StFull;
            r_result <= w_result;
            r_zero   <= (w_result == '0);
`endif
          end else if ((r_state == StFull) && out_ready) begin
            r_state <= StEmpty;
          end
        end
        StShift: begin
`ifdef ALU_SERIAL_SHIFT_EN
          r_shift_val <= w_shift_next;
          r_shift_cnt <= r_shift_cnt - ShW'(1);
          if (r_shift_cnt == ShW'(1)) begin
            r_state  <= StFull;
            r_result <= w_shift_next;
            r_zero   <= (w_shift_next == '0);
          end
`else
          r_state <= StEmpty;
`endif
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage; follows ALU_SERIAL_SHIFT_EN if defined.
module tb_alu_exec_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        busy;

  int n_checks;
  int n_pass;

  alu_exec_stage #(.DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle, then drop in_valid.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq(tag, ALUResult, exp);
    check_eq({tag, "_zero"}, {31'd0, Zero}, {31'd0, (exp == 32'd0)});
    tick();
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Operation = 4'b0000;
    SrcA      = '0;
    SrcB      = '0;
    tick();
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_result", ALUResult, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    tick();

    // Reset while FULL must clear immediately, without a clock edge.
    issue(4'b0100, 32'h0000_1000, 32'h0000_0234);
    check_eq("pre_rst_result", ALUResult, 32'h0000_1234);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("async_rst_result", ALUResult, 32'd0);
    check_eq("async_rst_zero", {31'd0, Zero}, 32'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;

    op_check("add_wrap", 4'b0100, 32'hFFFF_FFFF, 32'h1, 32'h0);
    op_check("sub", 4'b0010, 32'd5, 32'd7, 32'hFFFF_FFFE);
    op_check("slt_neg", 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1);
    op_check("slt_pos", 4'b1000, 32'd1, 32'hFFFF_FFFF, 32'd0);
    op_check("pass_b", 4'b1010, 32'h1111_1111, 32'hABCD_E000, 32'hABCD_E000);
    op_check("illegal", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
    op_check("and", 4'b0000, 32'hF0F0_FF00, 32'hFF00_0FF0, 32'hF000_0F00);
    op_check("or", 4'b0011, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    op_check("xor", 4'b0001, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0F0F_F0F0);

    // Backpressure: result held and no acceptance while out_ready is low.
    out_ready = 1'b0;
    issue(4'b0100, 32'd3, 32'd4);
    Operation = 4'b0001;
    SrcA      = 32'hF0;
    SrcB      = 32'hFF;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_result", ALUResult, 32'd7);
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("bp_xor", ALUResult, 32'h0000_000F);
    tick();

    // Back-to-back stream: one result per cycle, no bubbles.
    for (int i = 0; i < 8; i++) begin
      Operation = 4'b0100;
      SrcA      = 32'(i);
      SrcB      = 32'd100;
      in_valid  = 1'b1;
      tick();
      check_eq("stream_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stream_result", ALUResult, 32'(i + 100));
    end
    in_valid = 1'b0;
    tick();
    check_eq("stream_drained", {31'd0, out_valid}, 32'd0);

    // SRA 0x80000000 by 4; operand changes during the shift must be ignored.
    issue(4'b0111, 32'h8000_0000, 32'd4);
`ifdef ALU_SERIAL_SHIFT_EN
    SrcA = 32'h0;
    SrcB = 32'h0;
    for (int i = 0; i < 4; i++) begin
      check_eq("sra_busy", {31'd0, busy}, 32'd1);
      check_eq("sra_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("sra_not_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
`endif
    check_eq("sra_valid", {31'd0, out_valid}, 32'd1);
    check_eq("sra_busy_done", {31'd0, busy}, 32'd0);
    check_eq("sra_result", ALUResult, 32'hF800_0000);
    tick();

    // Shift by zero: latency 1 in either build.
    op_check("sll_by0", 4'b1101, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678);

    // Larger shifts: poll with a bounded wait, checking the expected latency.
    begin
      logic [3:0]  ops [3];
      logic [31:0] as  [3];
      logic [31:0] bs  [3];
      logic [31:0] exps[3];
      ops[0] = 4'b0101; as[0] = 32'hF000_00F0; bs[0] = 32'd4;  exps[0] = 32'h0F00_000F;
      ops[1] = 4'b1101; as[1] = 32'h0000_0001; bs[1] = 32'd31; exps[1] = 32'h8000_0000;
      ops[2] = 4'b0111; as[2] = 32'h4000_0000; bs[2] = 32'd3;  exps[2] = 32'h0800_0000;
      for (int k = 0; k < 3; k++) begin
        int lat;
        int exp_lat;
`ifdef ALU_SERIAL_SHIFT_EN
        exp_lat = int'(bs[k][4:0]) + 1;
`else
        exp_lat = 1;
`endif
        issue(ops[k], as[k], bs[k]);
        lat = 1;
        while (!out_valid && lat < 40) begin
          tick();
          lat++;
        end
        check_eq("shift_latency", 32'(lat), 32'(exp_lat));
        check_eq("shift_result", ALUResult, exps[k]);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute-stage ALU that consumes the 4-bit `Operation` code from the ALU controller together with two operands, and delivers the result and a zero flag to the EX/MEM boundary. It has a valid/ready handshake on both sides so hazard logic can stall it. Optionally, shifts run on a serial one-bit-per-cycle shifter in place of a barrel shifter, to save area.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width; power of two, ≥ 8.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `Operation`/`SrcA`/`SrcB` hold a valid request.
- `in_ready`  out  1  stage accepts a request this cycle.
- `Operation`  in  4  ALU operation code (encoding below).
- `SrcA`  in  DATA_W  operand A.
- `SrcB`  in  DATA_W  operand B; shift amount is `SrcB[$clog2(DATA_W)-1:0]`.
- `out_valid`  out  1  `ALUResult`/`Zero` hold a valid result.
- `out_ready`  in  1  downstream consumes the result this cycle.
- `ALUResult`  out  DATA_W  registered result.
- `Zero`  out  1  registered flag, `ALUResult == 0`.
- `busy`  out  1  serial shift in progress; constant 0 without the macro.

## Operation
Encoding (all arithmetic wraps mod 2^DATA_W):
- 0000 AND; 0001 XOR; 0011 OR.
- 0010 SUB (A−B); 0100 ADD (A+B).
- 0101 SRL; 0111 SRA; 1101 SLL.
- 1000 SLT: signed A<B → 1, else 0.
- 1010 PASS_B: result = B (LUI/JAL path).
- Any other code → result 0.

Behaviour:
- Accept when `in_valid && in_ready`.
- State machine states: EMPTY, SHIFT, FULL.
- EMPTY → FULL on accept of a non-shift op, or of any op without the macro.
- EMPTY → SHIFT on accept of a shift op with the macro defined.
- SHIFT → FULL when the remaining count reaches 0.
- FULL → EMPTY on `out_ready` with no new accept.
- FULL → FULL on `out_ready` with a simultaneous accept; the new result replaces the old.
- FULL holds `ALUResult`/`Zero` stable while `out_ready` = 0.
- `in_ready` = (state==EMPTY) || (state==FULL && out_ready). It is 0 in SHIFT.
- `out_valid` = (state==FULL).

## Timing
- Reset (async assert, any state): state EMPTY, `out_valid` 0, `ALUResult` 0, `Zero` 0, `busy` 0, shift counter 0. An in-flight shift is discarded.
- Non-shift ops: result is visible in the cycle after accept (latency 1).
- Full throughput of 1 op/cycle while `out_ready` = 1.
- Serial shift with shamt N:
  - N = 0: FULL in the cycle after accept, result = A.
  - N > 0: `busy` is high for N cycles, then `out_valid` rises. Accept-to-`out_valid` latency is N+1 cycles.
- SRA shifts in A[DATA_W−1] each step. SRL and SLL shift in 0.
- Inputs are sampled only at accept; changes to them during SHIFT are ignored.

## Configuration
- `ALU_SERIAL_SHIFT_EN` defined:
  - SRL/SRA/SLL use the serial shifter and the SHIFT state.
  - `busy` is driven as described in Timing.
- Undefined:
  - Single-cycle barrel shifter; all ops have latency 1.
  - SHIFT state is unreachable; `busy` is tied to 0.

## Test plan
- Reset mid-FULL with `ALUResult`=0x1234 → `out_valid`=0, `ALUResult`=0, `Zero`=0 immediately. First post-reset accept behaves normally.
- ADD 0xFFFFFFFF+1 → `ALUResult`=0, `Zero`=1. SUB 5−7 → 0xFFFFFFFE. SLT −1<1 → 1. PASS_B 0xABCDE000 → 0xABCDE000. Code 1111 → 0.
- Backpressure: accept ADD 3+4, hold `out_ready`=0 for 3 cycles.
  - Required: `ALUResult` stays 7 and `in_ready`=0.
  - On `out_ready`=1 with `in_valid` XOR 0xF0^0xFF: `ALUResult`=0x0F next cycle.
- Back-to-back stream of 8 ADDs with `out_ready`=1 → one result per cycle, in order, no bubbles.
- Macro on, SRA 0x80000000 by 4:
  - `busy` high for 4 cycles, `in_ready`=0 throughout.
  - Then `out_valid` with `ALUResult`=0xF8000000.
- Macro on, shift by 0 → latency 1, result = A. Same SRA test with macro off → latency 1, same value.
